// File: rtl/fetch_ctrl.sv
// Instruction fetch: drives the PC register, reads program memory, hands words to decode, applies redirects.
// Define FETCH_TIMEOUT_EN to add a request watchdog with a sticky ERR state.
module fetch_ctrl #(
  parameter int IW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    pc_addr,
  output logic          pc_en,
  output logic [7:0]    pc_d,
  output logic          mem_req,
  output logic [7:0]    mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr_data,
  output logic [7:0]    instr_pc,
  input  logic          br_valid,
  input  logic [7:0]    br_target,
  output logic          fetch_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD
`ifdef FETCH_TIMEOUT_EN
    , ERR
`endif
  } state_t;

  // The watchdog counter is 8 bits wide.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("fetch_ctrl: TIMEOUT must be in 1..255");
  end

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [IW-1:0] data_q, data_d;
  logic [7:0]    br_pc_d;

  // The PC register adds one on load, so redirects supply target-1.
  assign br_pc_d = br_target - 8'd1;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pc_en       = 1'b0;
    pc_d        = 8'h00;
    mem_req     = 1'b0;
    mem_addr    = 8'h00;
    instr_valid = 1'b0;
    instr_data  = '0;
    instr_pc    = 8'h00;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_addr;
        addr_d   = pc_addr;
        if (br_valid) begin
          // Without an ack the request is still open and must be drained at the old address.
          pc_en   = 1'b1;
          pc_d    = br_pc_d;
          state_d = mem_ack ? FETCH : DRAIN;
        end else if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = HOLD;
        end
      end

      DRAIN: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (br_valid) begin
          pc_en = 1'b1;
          pc_d  = br_pc_d;
        end
        if (mem_ack) state_d = FETCH;
      end

      HOLD: begin
        instr_valid = !br_valid;
        instr_data  = data_q;
        instr_pc    = pc_addr;
        if (br_valid) begin
          pc_en   = 1'b1;
          pc_d    = br_pc_d;
          state_d = FETCH;
        end else if (instr_ready) begin
          pc_en   = 1'b1;
          pc_d    = pc_addr;
          state_d = FETCH;
        end
      end

      default: ;
    endcase

`ifdef FETCH_TIMEOUT_EN
    cnt_d = cnt_q;
    if (mem_req && !mem_ack) begin
      if (cnt_q == TO_LAST) state_d = ERR;
      else                  cnt_d   = cnt_q + 8'd1;
    end
    if (state_d != state_q || mem_ack) cnt_d = 8'h00;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'h00;
    else       cnt_q <= cnt_d;
  end

  assign fetch_err = (state_q == ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and memory models around the DUT, scoreboard of fetched words.
module tb_fetch_ctrl;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    pc_addr;
  logic          pc_en;
  logic [7:0]    pc_d;
  logic          mem_req;
  logic [7:0]    mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_data;
  logic [7:0]    instr_pc;
  logic          br_valid;
  logic [7:0]    br_target;
  logic          fetch_err;

  fetch_ctrl #(.IW(IW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_en(pc_en), .pc_d(pc_d),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .br_valid(br_valid), .br_target(br_target), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         lat = 0;
  int         wcnt = 0;
  int         cyc = 0;
  int         err_cyc = 1 << 30;
  bit         pending = 1'b0;
  bit         drop = 1'b0;
  bit         pc_en_s = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] pc_d_s = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, want);
  endtask

  function automatic logic [7:0] next_pc();
    return pc_en_s ? pc_d_s + 8'd1 : pc_addr;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    br_valid = 1'b0; br_target = 8'h00; instr_ready = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; pc_addr = 8'h00;
    sb.delete(); pending = 1'b0; drop = 1'b0; pc_en_s = 1'b0; wcnt = 0; cyc = 0;
    @(posedge clk); #1;
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_pc_d", 32'(pc_d), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", 32'(instr_data), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_mem_req", 32'(mem_req), 32'd0);
    check("idle_pc_en", 32'(pc_en), 32'd0);
  endtask

  // One clock cycle: PC register update, memory response, then checks against the scoreboard.
  task automatic cycle(input logic br, input logic [7:0] tgt, input logic rdy);
    bit         hold_exp;
    bit         err_exp;
    bit         exp_en;
    logic [7:0] exp_d;
    @(posedge clk); #1;
    if (pc_en_s) pc_addr = pc_d_s + 8'd1;
    cyc++;
    br_valid = br; br_target = tgt; instr_ready = rdy;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    if (mem_req) begin
      if (!pending) begin
        pending = 1'b1; req_addr = mem_addr; wcnt = 0;
        check("req_addr", 32'(mem_addr), 32'(pc_addr));
      end else begin
        check("req_stable", 32'(mem_addr), 32'(req_addr));
      end
      if (wcnt >= lat) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hA000 + 16'(req_addr);
      end
    end
    @(negedge clk);
    hold_exp = sb.size() > 0;
    err_exp  = cyc >= err_cyc;
    exp_en   = !err_exp && (br || (hold_exp && rdy));
    exp_d    = br ? tgt - 8'd1 : pc_addr;
    check("mem_req", 32'(mem_req), 32'(!hold_exp && !err_exp));
    check("fetch_err", 32'(fetch_err), 32'(err_exp));
    check("pc_en", 32'(pc_en), 32'(exp_en));
    if (exp_en) check("pc_d", 32'(pc_d), 32'(exp_d));
    check("instr_valid", 32'(instr_valid), 32'(hold_exp && !br && !err_exp));
    if (hold_exp) begin
      if (!br) begin
        check("instr_pc", 32'(instr_pc), 32'(sb[0].pc));
        check("instr_data", 32'(instr_data), 32'(sb[0].data));
      end
      if (br || rdy) void'(sb.pop_front());
    end
    if (mem_ack) begin
      pending = 1'b0;
      if (!(br || drop)) sb.push_back('{req_addr, 16'hA000 + 16'(req_addr)});
      drop = 1'b0;
    end else if (mem_req) begin
      wcnt++;
      if (br) drop = 1'b1;
    end
    pc_en_s = pc_en;
    pc_d_s  = pc_d;
  endtask

  task automatic go_hold(input logic [7:0] pc);
    int n = 0;
    while (!(sb.size() > 0 && next_pc() == pc) && n < 200) begin
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("reach_hold", 32'(n < 200), 32'd1);
  endtask

  task automatic go_fetch(input logic [7:0] pc);
    int n = 0;
    while (!(sb.size() == 0 && !pending && next_pc() == pc) && n < 200) begin
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("reach_fetch", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch with zero-wait memory, then a decoder stall at PC 4.
    do_reset();
    lat = 0;
    repeat (8) cycle(1'b0, 8'h00, 1'b1);
    check("seq_pc4", 32'(next_pc()), 32'h04);
    repeat (6) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("pc_after_stall", 32'(pc_addr), 32'h05);

    // Redirect in HOLD wins over ready.
    go_hold(8'h07);
    cycle(1'b1, 8'h20, 1'b1);
    check("hold_br_pc_d", 32'(pc_d), 32'h1F);
    check("hold_br_no_valid", 32'(instr_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("fetch_after_br", 32'(mem_addr), 32'h20);

    // Redirect during a slow request drains the old address.
    do_reset();
    lat = 2;
    go_fetch(8'h09);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h40, 1'b1);
    check("drain_br_pc_d", 32'(pc_d), 32'h3F);
    cycle(1'b0, 8'h00, 1'b1);
    check("drain_addr", 32'(mem_addr), 32'h09);
    check("drain_no_valid", 32'(instr_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("fetch_40", 32'(mem_addr), 32'h40);

    go_fetch(8'h42);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    check("br_zero_pc_d", 32'(pc_d), 32'hFF);
    cycle(1'b0, 8'h00, 1'b1);
    check("drain_addr_42", 32'(mem_addr), 32'h42);
    cycle(1'b0, 8'h00, 1'b1);
    check("fetch_00", 32'(mem_addr), 32'h00);

    // Sequential wrap from PC FF.
    lat = 0;
    go_hold(8'h01);
    cycle(1'b1, 8'hFF, 1'b1);
    check("br_ff_pc_d", 32'(pc_d), 32'hFE);
    go_hold(8'hFF);
    cycle(1'b0, 8'h00, 1'b1);
    check("accept_ff_pc_d", 32'(pc_d), 32'hFF);
    cycle(1'b0, 8'h00, 1'b1);
    check("wrap_addr", 32'(mem_addr), 32'h00);

`ifdef FETCH_TIMEOUT_EN
    // Memory never acks: error 16 cycles after the request rises.
    do_reset();
    lat = 1 << 20;
    err_cyc = 17;
    repeat (17) cycle(1'b0, 8'h00, 1'b1);
    check("to_err", 32'(fetch_err), 32'd1);
    cycle(1'b1, 8'h30, 1'b1);
    check("to_br_ignored", 32'(pc_en), 32'd0);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);
    err_cyc = 1 << 30;
    lat = 0;
    do_reset();
    cycle(1'b0, 8'h00, 1'b1);
    check("to_restart_addr", 32'(mem_addr), 32'h00);
    check("to_restart_req", 32'(mem_req), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
